box_draw_sched: RTL and testbench

BOX_DRAW_SCHED -- requirements
Module: box_draw_sched

---
 rtl/box_draw_sched.sv | 200 ++++++++++++++++++++
 tb/tb_box_draw_sched.sv | 568 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_draw_sched.sv
// Box-draw scheduler: queues cell redraw requests and board sweeps,
// issuing one 64x24 box at a time to the box drawer.
module box_draw_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int COLS       = 10,
    parameter int ROWS       = 20
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       req_valid,
    input  logic [3:0] req_col,
    input  logic [4:0] req_row,
    input  logic [8:0] req_color,
    output logic       req_ready,
    input  logic       refresh,
    output logic [3:0] rd_col,
    output logic [4:0] rd_row,
    input  logic [8:0] rd_color,
    output logic       draw_start,
    output logic [9:0] draw_x0,
    output logic [8:0] draw_y0,
    output logic [8:0] draw_color,
    input  logic       draw_done,
    output logic       sweep_active,
    output logic       refresh_done,
    output logic       req_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

    state_t r_state, w_next;

    logic [17:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;

    logic [3:0] r_col;
    logic [4:0] r_row;
    logic       r_pend, r_again, r_active, r_last_sweep, r_is_sweep;
    logic       r_rdone, r_err;
    logic [9:0] r_x0;
    logic [8:0] r_y0, r_color;

    logic        w_in_range, w_accept, w_push, w_pop, w_empty;
    logic        w_sweep_req, w_grant_fifo, w_grant_sweep, w_sweep_start;
    logic        w_done, w_sweep_done, w_last_cell, w_last_done;
    logic [17:0] w_head;

    function automatic logic [8:0] f_y(input logic [4:0] r);
        return {r, 4'b0} + {1'b0, r, 3'b0};
    endfunction

    assign w_in_range = (req_col <= LAST_COL) && (req_row <= LAST_ROW);
    assign req_ready  = (r_cnt != FULL_CNT);
    assign w_accept   = req_valid & req_ready;
    assign w_push     = w_accept & w_in_range;
    assign w_empty    = (r_cnt == '0);
    assign w_head     = r_mem[r_rp];

    // Round-robin: the FIFO wins unless the sweep was passed over last time.
    assign w_sweep_req   = r_pend | r_active;
    assign w_grant_fifo  = (r_state == IDLE) & ~w_empty &
                           (~w_sweep_req | r_last_sweep);
    assign w_grant_sweep = (r_state == IDLE) & w_sweep_req & ~w_grant_fifo;
    assign w_sweep_start = w_grant_sweep & ~r_active;
    assign w_pop         = w_grant_fifo;

    assign w_done       = (r_state == WAIT) & draw_done;
    assign w_sweep_done = w_done & r_is_sweep;
    assign w_last_cell  = (r_col == LAST_COL) && (r_row == LAST_ROW);
    assign w_last_done  = w_sweep_done & w_last_cell;

    assign rd_col       = r_col;
    assign rd_row       = r_row;
    assign draw_start   = (r_state == ISSUE);
    assign draw_x0      = r_x0;
    assign draw_y0      = r_y0;
    assign draw_color   = r_color;
    assign sweep_active = r_active;
    assign refresh_done = r_rdone;
    assign req_err      = r_err;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_fifo)
                    w_next = ISSUE;
                else if (w_grant_sweep)
                    w_next = FETCH;
            end
            FETCH: w_next = ISSUE;
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (draw_done)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_push)
            r_mem[r_wp] <= {req_col, req_row, req_color};
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_in_range;
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_x0         <= '0;
            r_y0         <= '0;
            r_color      <= '0;
            r_is_sweep   <= 1'b0;
            r_last_sweep <= 1'b1;
        end else begin
            if (w_grant_fifo) begin
                r_x0         <= {w_head[17:14], 6'b0};
                r_y0         <= f_y(w_head[13:9]);
                r_color      <= w_head[8:0];
                r_is_sweep   <= 1'b0;
                r_last_sweep <= 1'b0;
            end else if (w_grant_sweep) begin
                r_is_sweep   <= 1'b1;
                r_last_sweep <= 1'b1;
            end
            if (r_state == FETCH) begin
                r_x0    <= {r_col, 6'b0};
                r_y0    <= f_y(r_row);
                r_color <= rd_color;
            end
        end
    end

    // A refresh arriving mid-sweep is remembered and restarts the board.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_col    <= '0;
            r_row    <= '0;
            r_pend   <= 1'b0;
            r_again  <= 1'b0;
            r_active <= 1'b0;
            r_rdone  <= 1'b0;
        end else begin
            r_rdone <= w_last_done;
            if (w_sweep_done) begin
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_last_done) begin
                r_active <= 1'b0;
                r_pend   <= r_again | refresh;
                r_again  <= 1'b0;
            end else begin
                if (w_sweep_start) begin
                    r_active <= 1'b1;
                    r_pend   <= 1'b0;
                end else if (refresh && !r_active) begin
                    r_pend <= 1'b1;
                end
                if (refresh && (r_active || w_sweep_start))
                    r_again <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_box_draw_sched.sv
// Randomized self-checking bench for box_draw_sched against a
// sequence-level model of requests, sweeps and arbitration.
module tb_box_draw_sched;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_col = '0;
    logic [4:0] req_row = '0;
    logic [8:0] req_color = '0;
    logic       req_ready;
    logic       refresh = 1'b0;
    logic [3:0] rd_col;
    logic [4:0] rd_row;
    logic [8:0] rd_color = '0;
    logic       draw_start;
    logic [9:0] draw_x0;
    logic [8:0] draw_y0;
    logic [8:0] draw_color;
    logic       draw_done;
    logic       sweep_active, refresh_done, req_err;

    box_draw_sched dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .req_valid(req_valid), .req_col(req_col), .req_row(req_row),
        .req_color(req_color), .req_ready(req_ready),
        .refresh(refresh),
        .rd_col(rd_col), .rd_row(rd_row), .rd_color(rd_color),
        .draw_start(draw_start), .draw_x0(draw_x0), .draw_y0(draw_y0),
        .draw_color(draw_color), .draw_done(draw_done),
        .sweep_active(sweep_active), .refresh_done(refresh_done),
        .req_err(req_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [8:0] c;
    } box_t;

    box_t log_q[$];
    int   checks = 0, errors = 0;
    int   start_cnt = 0, rdone_cnt = 0, err_cnt = 0, stab_err = 0;
    logic auto_en = 1'b0, man_done = 1'b0, auto_done = 1'b0;
    int   auto_delay = 3;
    logic outstanding = 1'b0;
    int   wcnt = 0;
    logic hold = 1'b0;
    box_t held;

    assign draw_done = auto_done | man_done;

    // Board RAM: every cell holds col + row*16, one-cycle read latency.
    always @(posedge CLOCK_50)
        rd_color <= 9'(int'(rd_col) + int'(rd_row) * 16);

    always @(posedge CLOCK_50) begin
        if (refresh_done) rdone_cnt++;
        if (req_err) err_cnt++;
        if (!resetn) begin
            hold <= 1'b0;
        end else begin
            if (hold && ({draw_x0, draw_y0, draw_color} !== held))
                stab_err++;
            if (draw_start) begin
                start_cnt++;
                held <= {draw_x0, draw_y0, draw_color};
                hold <= 1'b1;
                log_q.push_back({draw_x0, draw_y0, draw_color});
            end else if (draw_done) begin
                hold <= 1'b0;
            end
        end
    end

    always @(posedge CLOCK_50) begin
        auto_done <= 1'b0;
        if (!resetn) begin
            outstanding <= 1'b0;
        end else if (draw_start) begin
            outstanding <= 1'b1;
            wcnt <= 1;
        end else if (man_done) begin
            outstanding <= 1'b0;
        end else if (outstanding && auto_en && !auto_done) begin
            if (wcnt >= auto_delay) begin
                auto_done <= 1'b1;
                outstanding <= 1'b0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    function automatic box_t exp_box(input int c, input int r, input int k);
        box_t b;
        b.x = 10'(c * 64);
        b.y = 9'(r * 24);
        b.c = 9'(k);
        return b;
    endfunction

    task automatic do_reset();
        @(negedge CLOCK_50);
        resetn = 1'b0;
        req_valid = 1'b0;
        refresh = 1'b0;
        man_done = 1'b0;
        auto_en = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        log_q.delete();
        @(negedge CLOCK_50);
    endtask

    task automatic push_req(input logic [3:0] c, input logic [4:0] r,
                            input logic [8:0] k, input int budget,
                            output bit ok);
        req_valid = 1'b1;
        req_col = c;
        req_row = r;
        req_color = k;
        ok = 1'b0;
        for (int w = 0; w < budget; w++) begin
            if (req_ready) begin
                @(negedge CLOCK_50);
                ok = 1'b1;
                break;
            end
            @(negedge CLOCK_50);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_boxes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && log_q.size() < n; i++)
            @(negedge CLOCK_50);
        if (log_q.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_rdone(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && rdone_cnt < n; i++)
            @(negedge CLOCK_50);
        if (rdone_cnt >= n) ok = 1'b1;
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        @(negedge CLOCK_50);
        man_done = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLOCK_50);
        checks++;
        if (draw_start !== 1'b0) begin
            errors++; $display("FAIL rst_start got %b exp 0", draw_start);
        end
        checks++;
        if ({draw_x0, draw_y0, draw_color} !== 28'd0) begin
            errors++;
            $display("FAIL rst_cmd got %h %h %h exp 0", draw_x0, draw_y0, draw_color);
        end
        checks++;
        if ({sweep_active, refresh_done, req_err} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags got %b%b%b exp 000", sweep_active, refresh_done, req_err);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready got %b exp 1", req_ready);
        end
        checks++;
        if ({rd_col, rd_row} !== 9'd0) begin
            errors++; $display("FAIL rst_rdaddr got %h %h exp 0", rd_col, rd_row);
        end
        resetn = 1'b1;
        @(negedge CLOCK_50);
    endtask

    task automatic test_single();
        int s0;
        do_reset();
        s0 = start_cnt;
        req_valid = 1'b1;
        req_col = 4'd3;
        req_row = 5'd5;
        req_color = 9'h1C0;
        @(negedge CLOCK_50);
        req_valid = 1'b0;
        checks++;
        if (draw_start !== 1'b0) begin
            errors++; $display("FAIL single_early got %b exp 0", draw_start);
        end
        @(negedge CLOCK_50);
        checks++;
        if ({draw_start, draw_x0, draw_y0, draw_color} !== {1'b1, 10'd192, 9'd120, 9'h1C0}) begin
            errors++;
            $display("FAIL single_cmd got %b %0d %0d %h exp 1 192 120 1c0",
                     draw_start, draw_x0, draw_y0, draw_color);
        end
        @(negedge CLOCK_50);
        checks++;
        if (draw_start !== 1'b0) begin
            errors++; $display("FAIL single_onecycle got %b exp 0", draw_start);
        end
        repeat (4) @(negedge CLOCK_50);
        checks++;
        if ({draw_x0, draw_y0, draw_color} !== {10'd192, 9'd120, 9'h1C0}) begin
            errors++;
            $display("FAIL single_hold got %0d %0d %h exp 192 120 1c0", draw_x0, draw_y0, draw_color);
        end
        pulse_done();
        repeat (4) @(negedge CLOCK_50);
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++; $display("FAIL single_starts got %0d exp 1", start_cnt - s0);
        end
    endtask

    task automatic test_fifo_full();
        box_t exp_q[$];
        int s0, c, r, k;
        bit ok;
        do_reset();
        s0 = start_cnt;
        auto_delay = $urandom_range(1, 4);
        for (int i = 0; i < 6; i++) begin
            c = $urandom_range(0, 9);
            r = $urandom_range(0, 19);
            k = $urandom_range(0, 511);
            exp_q.push_back(exp_box(c, r, k));
            if (i < 5) begin
                push_req(4'(c), 5'(r), 9'(k), 4, ok);
                checks++;
                if (ok !== 1'b1) begin
                    errors++; $display("FAIL full_push%0d got 0 exp 1", i);
                end
            end else begin
                req_valid = 1'b1;
                req_col = 4'(c);
                req_row = 5'(r);
                req_color = 9'(k);
            end
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got %b exp 0", req_ready);
        end
        repeat (4) @(negedge CLOCK_50);
        checks++;
        if ({req_ready, 32'(start_cnt - s0)} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL full_stall got %b %0d exp 0 1", req_ready, start_cnt - s0);
        end
        pulse_done();
        ok = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (req_ready) begin
                @(negedge CLOCK_50);
                ok = 1'b1;
                break;
            end
            @(negedge CLOCK_50);
        end
        req_valid = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL full_fifth got 0 exp 1");
        end
        auto_en = 1'b1;
        wait_boxes(6, 300, ok);
        repeat (10) @(negedge CLOCK_50);
        checks++;
        if (log_q.size() !== 6) begin
            errors++; $display("FAIL full_count got %0d exp 6", log_q.size());
        end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_order[%0d] got %h exp %h", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_bad_req();
        int s0, e0;
        bit ok;
        box_t e;
        do_reset();
        s0 = start_cnt;
        e0 = err_cnt;
        push_req(4'd10, 5'd2, 9'h0AA, 4, ok);
        checks++;
        if ({ok, req_err} !== 2'b11) begin
            errors++; $display("FAIL bad_col_err got %b%b exp 11", ok, req_err);
        end
        @(negedge CLOCK_50);
        checks++;
        if (req_err !== 1'b0) begin
            errors++; $display("FAIL bad_pulse got %b exp 0", req_err);
        end
        push_req(4'd4, 5'd20, 9'h055, 4, ok);
        repeat (5) @(negedge CLOCK_50);
        checks++;
        if ({32'(start_cnt - s0), 32'(err_cnt - e0)} !== {32'd0, 32'd2}) begin
            errors++;
            $display("FAIL bad_nodraw got starts %0d errs %0d exp 0 2",
                     start_cnt - s0, err_cnt - e0);
        end
        push_req(4'd9, 5'd19, 9'h155, 4, ok);
        wait_boxes(1, 20, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL bad_edge_timeout got 0 exp 1");
        end
        e = exp_box(9, 19, 9'h155);
        if (ok) begin
            checks++;
            if (log_q[0] !== e) begin
                errors++; $display("FAIL bad_edge_box got %h exp %h", log_q[0], e);
            end
        end
        pulse_done();
        @(negedge CLOCK_50);
    endtask

    task automatic test_sweep();
        int r0;
        bit ok;
        box_t e;
        do_reset();
        auto_en = 1'b1;
        auto_delay = 3;
        r0 = rdone_cnt;
        refresh = 1'b1;
        @(negedge CLOCK_50);
        refresh = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        checks++;
        if (sweep_active !== 1'b1) begin
            errors++; $display("FAIL sweep_active_on got %b exp 1", sweep_active);
        end
        wait_rdone(r0 + 1, 4000, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL sweep_timeout got %0d exp %0d", rdone_cnt, r0 + 1);
        end
        repeat (20) @(negedge CLOCK_50);
        checks++;
        if (log_q.size() !== 200) begin
            errors++; $display("FAIL sweep_count got %0d exp 200", log_q.size());
        end
        for (int i = 0; i < 200 && i < log_q.size(); i++) begin
            e = exp_box(i % 10, i / 10, (i % 10) + (i / 10) * 16);
            checks++;
            if (log_q[i] !== e) begin
                errors++; $display("FAIL sweep_box[%0d] got %h exp %h", i, log_q[i], e);
            end
        end
        if (log_q.size() == 200) begin
            checks++;
            if ({log_q[199].x, log_q[199].y} !== {10'd576, 9'd456}) begin
                errors++;
                $display("FAIL sweep_last got %0d %0d exp 576 456", log_q[199].x, log_q[199].y);
            end
        end
        checks++;
        if ({32'(rdone_cnt - r0), sweep_active} !== {32'd1, 1'b0}) begin
            errors++;
            $display("FAIL sweep_end got rdone %0d active %b exp 1 0", rdone_cnt - r0, sweep_active);
        end
    endtask

    task automatic test_refresh_again();
        int r0;
        bit ok;
        box_t e;
        do_reset();
        auto_en = 1'b1;
        auto_delay = 1;
        r0 = rdone_cnt;
        refresh = 1'b1;
        @(negedge CLOCK_50);
        refresh = 1'b0;
        wait_boxes(50, 1000, ok);
        refresh = 1'b1;
        @(negedge CLOCK_50);
        refresh = 1'b0;
        repeat (7) @(negedge CLOCK_50);
        refresh = 1'b1;
        @(negedge CLOCK_50);
        refresh = 1'b0;
        wait_rdone(r0 + 2, 8000, ok);
        repeat (30) @(negedge CLOCK_50);
        checks++;
        if ({32'(rdone_cnt - r0), 32'(log_q.size()), sweep_active} !== {32'd2, 32'd400, 1'b0}) begin
            errors++;
            $display("FAIL again_end got rdone %0d boxes %0d active %b exp 2 400 0",
                     rdone_cnt - r0, log_q.size(), sweep_active);
        end
        for (int i = 0; i < 400 && i < log_q.size(); i++) begin
            e = exp_box(i % 10, (i / 10) % 20, (i % 10) + ((i / 10) % 20) * 16);
            checks++;
            if (log_q[i] !== e) begin
                errors++; $display("FAIL again_box[%0d] got %h exp %h", i, log_q[i], e);
            end
        end
    endtask

    task automatic test_arbitration();
        box_t sw_q[$], rq_q[$], exp_q[$];
        bit last_sweep, ok;
        int r0, c, r, k;
        do_reset();
        auto_en = 1'b1;
        auto_delay = 8;
        r0 = rdone_cnt;
        for (int i = 0; i < 200; i++)
            sw_q.push_back(exp_box(i % 10, i / 10, (i % 10) + (i / 10) * 16));
        refresh = 1'b1;
        @(negedge CLOCK_50);
        refresh = 1'b0;
        wait_boxes(1, 20, ok);
        for (int i = 0; i < 2; i++) begin
            c = $urandom_range(0, 9);
            r = $urandom_range(0, 19);
            k = $urandom_range(0, 511);
            rq_q.push_back(exp_box(c, r, k));
            push_req(4'(c), 5'(r), 9'(k), 4, ok);
        end
        exp_q.push_back(sw_q.pop_front());
        last_sweep = 1'b1;
        while (sw_q.size() > 0 || rq_q.size() > 0) begin
            if (rq_q.size() > 0 && (sw_q.size() == 0 || last_sweep)) begin
                exp_q.push_back(rq_q.pop_front());
                last_sweep = 1'b0;
            end else begin
                exp_q.push_back(sw_q.pop_front());
                last_sweep = 1'b1;
            end
        end
        wait_rdone(r0 + 1, 6000, ok);
        repeat (20) @(negedge CLOCK_50);
        checks++;
        if (log_q.size() !== 202) begin
            errors++; $display("FAIL arb_count got %0d exp 202", log_q.size());
        end
        for (int i = 0; i < 202 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL arb_box[%0d] got %h exp %h", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        bit ok;
        box_t e;
        do_reset();
        push_req(4'd2, 5'd3, 9'h0F0, 4, ok);
        wait_boxes(1, 10, ok);
        refresh = 1'b1;
        @(negedge CLOCK_50);
        refresh = 1'b0;
        @(negedge CLOCK_50);
        resetn = 1'b0;
        #1;
        checks++;
        if ({draw_start, draw_x0, draw_y0, draw_color, sweep_active, req_ready} !==
            {1'b0, 28'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset got %b %h %h %h %b %b exp 0 0 0 0 0 1", draw_start,
                     draw_x0, draw_y0, draw_color, sweep_active, req_ready);
        end
        @(negedge CLOCK_50);
        resetn = 1'b1;
        s0 = start_cnt;
        @(negedge CLOCK_50);
        pulse_done();
        repeat (10) @(negedge CLOCK_50);
        checks++;
        if ({32'(start_cnt - s0), draw_x0, draw_y0, draw_color, sweep_active} !==
            {32'd0, 28'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_idle got starts %0d cmd %h %h %h active %b exp 0", start_cnt - s0,
                     draw_x0, draw_y0, draw_color, sweep_active);
        end
        push_req(4'd1, 5'd1, 9'h033, 4, ok);
        wait_boxes(2, 10, ok);
        e = exp_box(1, 1, 9'h033);
        checks++;
        if (ok !== 1'b1 || log_q[log_q.size() - 1] !== e) begin
            errors++; $display("FAIL mid_new got %h exp %h", log_q[log_q.size() - 1], e);
        end
        pulse_done();
        @(negedge CLOCK_50);
    endtask

    task automatic test_random();
        box_t exp_q[$];
        int e0, nbad, c, r, k;
        bit ok;
        do_reset();
        auto_en = 1'b1;
        auto_delay = $urandom_range(1, 5);
        e0 = err_cnt;
        nbad = 0;
        for (int i = 0; i < 40; i++) begin
            c = $urandom_range(0, 11);
            r = $urandom_range(0, 21);
            k = $urandom_range(0, 511);
            push_req(4'(c), 5'(r), 9'(k), 200, ok);
            checks++;
            if (ok !== 1'b1) begin
                errors++; $display("FAIL rnd_push%0d got 0 exp 1", i);
            end
            if (c < 10 && r < 20) exp_q.push_back(exp_box(c, r, k));
            else nbad++;
            repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
        end
        wait_boxes(exp_q.size(), 2000, ok);
        repeat (15) @(negedge CLOCK_50);
        checks++;
        if ({32'(log_q.size()), 32'(err_cnt - e0)} !== {32'(exp_q.size()), 32'(nbad)}) begin
            errors++;
            $display("FAIL rnd_counts got boxes %0d errs %0d exp %0d %0d",
                     log_q.size(), err_cnt - e0, exp_q.size(), nbad);
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rnd_box[%0d] got %h exp %h", i, log_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stab_err !== 0) begin
            errors++; $display("FAIL hold_stable got %0d exp 0", stab_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_bad_req();
        test_sweep();
        test_refresh_again();
        test_arbitration();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
